// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between instruction fetch (IF) and data memory (DM).
// Each access runs IDLE -> GRANT_xx -> DONE. DM normally wins arbitration.
// A run counter limits how many DM grants in a row can be made while IF waits.
// A per-access cycle counter aborts a grant whose RAM never answers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no access in flight; arbitrate and latch the winner's request
// GRANT_IF | fetch read on the RAM; strobe held until mem_ready or timeout
// GRANT_DM | load/store on the RAM; strobe held until mem_ready or timeout
// DONE     | one-cycle completion pulse to the served requester
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_DM_RUN = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              timeout_err
);

    localparam int RUN_W = (MAX_DM_RUN < 1) ? 1 : $clog2(MAX_DM_RUN + 1);
    localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);
    localparam logic [TMO_W:0]   TMO_LIM = (TMO_W + 1)'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              served_dm_q, served_dm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic [RUN_W-1:0]  dm_run_q, dm_run_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic [TMO_W:0]    tmo_inc;
    logic              read_en, write_en;
    logic              if_forced;

    // State and datapath registers; async reset returns everything to idle/zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            served_dm_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            dm_run_q      <= '0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            served_dm_q   <= served_dm_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            if_rdata_q    <= if_rdata_d;
            dm_rdata_q    <= dm_rdata_d;
            dm_run_q      <= dm_run_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Arbitration, request latching, strobe generation, capture and timeout.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        served_dm_d   = served_dm_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        if_rdata_d    = if_rdata_q;
        dm_rdata_d    = dm_rdata_q;
        dm_run_d      = dm_run_q;
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
        read_en       = 1'b0;
        write_en      = 1'b0;
        tmo_inc       = {1'b0, tmo_cnt_q} + 1'b1;
        // IF has waited through the maximum DM run and must go next.
        if_forced     = if_req && (dm_run_q == RUN_MAX);

        unique case (state_q)
            IDLE: begin
                if (dm_req && !if_forced) begin
                    state_d     = GRANT_DM;
                    served_dm_d = 1'b1;
                    we_d        = dm_we;
                    addr_d      = dm_addr;
                    wdata_d     = dm_wdata;
                    tmo_cnt_d   = '0;
                    if (!if_req) begin
                        dm_run_d = '0;
                    end else if (dm_run_q != RUN_MAX) begin
                        dm_run_d = dm_run_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d     = GRANT_IF;
                    served_dm_d = 1'b0;
                    we_d        = 1'b0;
                    addr_d      = if_addr;
                    wdata_d     = '0;
                    tmo_cnt_d   = '0;
                    dm_run_d    = '0;
                end
            end
            GRANT_IF, GRANT_DM: begin
                read_en   = (state_q == GRANT_IF) || !we_q;
                write_en  = (state_q == GRANT_DM) && we_q;
                tmo_cnt_d = tmo_inc[TMO_W-1:0];
                if (mem_ready) begin
                    state_d = DONE;
                    if (state_q == GRANT_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else if ((TIMEOUT != 0) && (tmo_inc == TMO_LIM)) begin
                    // Abort: strobes drop on entering DONE, rdata keeps its old value.
                    state_d       = DONE;
                    timeout_err_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign mem_read_en  = read_en;
    assign mem_write_en = write_en;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign timeout_err  = timeout_err_q;
    assign if_valid     = (state_q == DONE) && !served_dm_q;
    assign dm_done      = (state_q == DONE) && served_dm_q;
    assign stall        = (if_req || dm_req) && !(if_valid || dm_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single-requester accesses,
// then hand-written sequences for arbitration, DM run limit, timeout and reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    // RAM model controls: answer after ram_lat strobe cycles (0 = never).
    int          ram_lat = 1;
    logic [31:0] ram_rdata = '0;
    int          ram_cnt = 0;
    logic        grant_q[$];

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DM_RUN(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // RAM model; also logs each new grant (addr bit 13 set = DM in the sequences).
    always @(posedge clk) begin
        #1;
        if (mem_read_en || mem_write_en) begin
            ram_cnt++;
            if (ram_cnt == 1) grant_q.push_back(mem_addr[13]);
        end else begin
            ram_cnt = 0;
        end
        if (ram_lat != 0 && ram_cnt == ram_lat) begin
            mem_ready = 1'b1;
            mem_rdata = ram_rdata;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'hFFFF_FFFF;
        end
    end

    // Requests must be held until their completion pulse.
    logic if_pend, dm_pend;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pend <= 1'b0;
            dm_pend <= 1'b0;
        end else begin
            assert (!(if_pend && !if_req && !if_valid))
                else $error("if_req withdrawn before if_valid");
            assert (!(dm_pend && !dm_req && !dm_done))
                else $error("dm_req withdrawn before dm_done");
            if_pend <= if_req && !if_valid;
            dm_pend <= dm_req && !dm_done;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] ram_data;
        logic        exp_re;
        logic        exp_we;
        logic [31:0] exp_rdata;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[6];

    // One single-requester access; cycle 1 is the IDLE cycle the request appears in.
    task automatic run_vec(input int idx, input vec_t v);
        int  n;
        bit  seen;
        bit  got;
        ram_lat   = v.lat;
        ram_rdata = v.ram_data;
        @(negedge clk);
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        chk($sformatf("v%0d stall_idle", idx), 32'(stall), 32'd1);
        n = 1; seen = 0; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            n++;
            if (!seen && (mem_read_en || mem_write_en)) begin
                seen = 1;
                chk($sformatf("v%0d read_en", idx), 32'(mem_read_en), 32'(v.exp_re));
                chk($sformatf("v%0d write_en", idx), 32'(mem_write_en), 32'(v.exp_we));
                chk($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
                if (v.we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
            end
            if (if_valid || dm_done) begin
                got = 1;
                chk($sformatf("v%0d cycles", idx), 32'(n), 32'(v.exp_cycles));
                chk($sformatf("v%0d pulse_kind", idx), {30'd0, if_valid, dm_done},
                    v.is_dm ? 32'd1 : 32'd2);
                chk($sformatf("v%0d rdata", idx), v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
                chk($sformatf("v%0d stall_done", idx), 32'(stall), 32'd0);
                if_req = 1'b0;
                dm_req = 1'b0;
            end
        end
        if (!got) begin
            chk($sformatf("v%0d completion_seen", idx), 32'd0, 32'd1);
            if_req = 1'b0;
            dm_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, n_dm, n_if, dm_cnt, strobes;
        bit   done_flag;
        logic exp_order[7];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        //        is_dm we   addr          wdata         lat ram_data      re    we    exp_rdata     cyc
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        2, 32'h0050_0093, 1'b1, 1'b0, 32'h0050_0093, 4};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1, 32'h1122_3344, 1'b1, 1'b0, 32'h1122_3344, 3};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1, 32'hBAD0_BAD0, 1'b0, 1'b1, 32'h1122_3344, 3};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        1, 32'h00A0_0113, 1'b1, 1'b0, 32'h00A0_0113, 3};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        3, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 5};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0084, 32'h1234_5678, 2, 32'h5555_AAAA, 1'b0, 1'b1, 32'hCAFE_F00D, 4};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst if_rdata", if_rdata, 32'h0);
        chk("rst if_valid", 32'(if_valid), 32'h0);
        chk("rst dm_rdata", dm_rdata, 32'h0);
        chk("rst dm_done", 32'(dm_done), 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst strobes", {30'd0, mem_read_en, mem_write_en}, 32'h0);
        chk("rst stall", 32'(stall), 32'h0);
        chk("rst timeout_err", 32'(timeout_err), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // IF and DM together: DM first (done cycle 3), IF follows (valid cycle 6).
        ram_lat = 1; ram_rdata = 32'h1357_9BDF;
        grant_q.delete();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_1000;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000;
        n = 1; n_dm = 0; n_if = 0;
        for (int k = 0; k < 30 && n_if == 0; k++) begin
            @(negedge clk);
            n++;
            if (dm_done) begin n_dm = n; dm_req = 1'b0; end
            if (if_valid) begin n_if = n; if_req = 1'b0; end
        end
        if_req = 1'b0; dm_req = 1'b0;
        chk("both dm_done_cycle", 32'(n_dm), 32'd3);
        chk("both if_valid_cycle", 32'(n_if), 32'd6);
        chk("both first_grant_dm", grant_q.size() > 0 ? 32'(grant_q[0]) : 32'hEEEE, 32'd1);
        chk("both dm_rdata", dm_rdata, 32'h1357_9BDF);
        chk("both if_rdata", if_rdata, 32'h1357_9BDF);

        // DM run limit: DM held for 6 accesses while IF waits.
        ram_lat = 1; ram_rdata = 32'h2468_ACE0;
        grant_q.delete();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_1100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2040;
        dm_cnt = 0; done_flag = 0;
        for (int k = 0; k < 100 && !done_flag; k++) begin
            @(negedge clk);
            if (dm_done) begin
                dm_cnt++;
                if (dm_cnt == 6) dm_req = 1'b0;
            end
            if (if_valid) if_req = 1'b0;
            if (dm_cnt == 6 && !if_req) done_flag = 1;
        end
        if_req = 1'b0; dm_req = 1'b0;
        chk("run grant_count", 32'(grant_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("run grant%0d_is_dm", i),
                i < grant_q.size() ? 32'(grant_q[i]) : 32'hEEEE, 32'(exp_order[i]));
        end

        // Timeout: RAM never answers.
        ram_lat = 0;
        @(negedge clk);
        chk("tmo err_before", 32'(timeout_err), 32'd0);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2080;
        n = 1; n_dm = 0; strobes = 0;
        for (int k = 0; k < 40 && n_dm == 0; k++) begin
            @(negedge clk);
            n++;
            if (mem_read_en) strobes++;
            if (dm_done) begin n_dm = n; dm_req = 1'b0; end
        end
        dm_req = 1'b0;
        chk("tmo strobe_cycles", 32'(strobes), 32'd15);
        chk("tmo done_cycle", 32'(n_dm), 32'd17);
        chk("tmo err_set", 32'(timeout_err), 32'd1);
        chk("tmo dm_rdata_kept", dm_rdata, 32'h2468_ACE0);
        run_vec(6, vecs[3]);
        chk("tmo err_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of a store grant.
        ram_lat = 0;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_2100; dm_wdata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        chk("rst_mid write_en_before", 32'(mem_write_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid write_en_async", 32'(mem_write_en), 32'd0);
        chk("rst_mid dm_done", 32'(dm_done), 32'd0);
        @(negedge clk);
        dm_req = 1'b0;
        @(negedge clk);
        chk("rst_mid dm_done_hold", 32'(dm_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_mid strobes", {30'd0, mem_read_en, mem_write_en}, 32'd0);
        chk("rst_mid dm_done_after", 32'(dm_done), 32'd0);
        chk("rst_mid dm_rdata", dm_rdata, 32'd0);
        // Fresh access after reset proves the FSM restarted from IDLE.
        run_vec(7, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
